// File: rtl/l1_trigger_event_builder_if.sv
`default_nettype none
// ============================================================================
// Module      : l1_trigger_event_builder_if
// Description : Valid/ready event stream between the L1 event builder and the
//               downstream trigger link.
//               m_valid_o : producer has a word at the head of its queue
//               m_ready_i : consumer accepts the head word this cycle
//               m_data_o  : {timestamp, beam_mask} head word
// Revision    : 1.0 - initial release
// ============================================================================
interface l1_trigger_event_builder_if #(
    parameter int DATA_W = 34
) ();
    logic              m_valid_o;
    logic              m_ready_i;
    logic [DATA_W-1:0] m_data_o;

    modport master (output m_valid_o, output m_data_o, input m_ready_i);
    modport slave  (input m_valid_o, input m_data_o, output m_ready_i);
endinterface
`default_nettype wire

// File: rtl/l1_trigger_event_builder.sv
`default_nettype none
// ============================================================================
// Module      : l1_trigger_event_builder
// Description : Merges per-beam L1 trigger hits inside a short coincidence
//               window into one event, applies a dead-time holdoff, and
//               queues {timestamp, beam_mask} words in a first-word-fall-
//               through FIFO drained over a valid/ready stream.
// Ports       : aclk, aresetn        clock / async active-low reset
//               trig_i, beam_en_i    per-beam trigger bits and enables
//               enable_i             gates the start of new events
//               clear_i              zeroes timestamp and statistics counters
//               m_if (master)        event stream {m_valid_o,m_ready_i,m_data_o}
//               fifo_count_o         FIFO occupancy
//               overflow_cnt_o       events dropped on a full FIFO (saturating)
//               suppress_cnt_o       holdoff cycles that saw a hit (saturating)
//               busy_o               FSM is gathering or in holdoff
// Revision    : 1.0 - initial release
// ============================================================================
module l1_trigger_event_builder #(
    parameter int NBEAMS         = 2,
    parameter int TS_BITS        = 32,
    parameter int GATHER_CLOCKS  = 4,
    parameter int HOLDOFF_CLOCKS = 16,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NBEAMS-1:0]             trig_i,
    input  logic [NBEAMS-1:0]             beam_en_i,
    input  logic                          enable_i,
    input  logic                          clear_i,
    l1_trigger_event_builder_if.master    m_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [15:0]                   overflow_cnt_o,
    output logic [15:0]                   suppress_cnt_o,
    output logic                          busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = TS_BITS + NBEAMS;
    // Gather counter runs 1..GATHER_CLOCKS-1, holdoff counter 0..HOLDOFF_CLOCKS-1
    localparam int GW = (GATHER_CLOCKS > 1) ? $clog2(GATHER_CLOCKS) : 1;
    localparam int HW = (HOLDOFF_CLOCKS > 1) ? $clog2(HOLDOFF_CLOCKS) : 1;

    localparam logic [GW-1:0] c_gather_last = GW'(GATHER_CLOCKS - 1);
    localparam logic [HW-1:0] c_hold_last   = HW'(HOLDOFF_CLOCKS - 1);
    localparam logic [AW:0]   c_depth       = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GATHER  = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    state_t              r_state;
    logic [GW-1:0]       r_gcnt;
    logic [HW-1:0]       r_hcnt;
    logic [TS_BITS-1:0]  r_ts;
    logic [TS_BITS-1:0]  r_ev_ts;
    logic [NBEAMS-1:0]   r_mask;

    logic [DW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [AW:0]         r_count;
    logic [15:0]         r_ovf_cnt;
    logic [15:0]         r_sup_cnt;

    logic [NBEAMS-1:0]   w_hit;
    logic                w_hit_any;
    logic                w_start;
    logic                w_push;
    logic [DW-1:0]       w_push_data;
    logic                w_full;
    logic                w_valid;
    logic                w_wr;
    logic                w_rd;

    assign w_hit     = trig_i & beam_en_i;
    assign w_hit_any = |w_hit;
    assign w_start   = (r_state == S_IDLE) && w_hit_any && enable_i;

    // The push is combinational in the last window cycle so the word lands in
    // the FIFO on that edge and is visible at N+GATHER_CLOCKS.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = {r_ev_ts, r_mask | w_hit};
        if ((r_state == S_GATHER) && (r_gcnt == c_gather_last)) begin
            w_push = 1'b1;
        end
        if ((GATHER_CLOCKS == 1) && w_start) begin
            w_push      = 1'b1;
            w_push_data = {r_ts, w_hit};
        end
    end

    // ---------------------------------------------------------------- timestamp
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ts <= '0;
        end else if (clear_i) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_BITS'(1);
        end
    end

    // ---------------------------------------------------------------- event FSM
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
            r_gcnt  <= '0;
            r_hcnt  <= '0;
            r_ev_ts <= '0;
            r_mask  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_ev_ts <= r_ts;
                        r_mask  <= w_hit;
                        r_gcnt  <= GW'(1);
                        r_hcnt  <= '0;
                        r_state <= (GATHER_CLOCKS == 1) ? S_HOLDOFF : S_GATHER;
                    end
                end
                S_GATHER: begin
                    // enable_i is deliberately ignored: a started event completes
                    r_mask <= r_mask | w_hit;
                    if (r_gcnt == c_gather_last) begin
                        r_hcnt  <= '0;
                        r_state <= S_HOLDOFF;
                    end else begin
                        r_gcnt <= r_gcnt + GW'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (r_hcnt == c_hold_last) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hcnt <= r_hcnt + HW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- FIFO
    // Full is judged on the pre-pop count, so a push into a full FIFO is
    // dropped even when a pop happens in the same cycle.
    assign w_full  = (r_count == c_depth);
    assign w_valid = (r_count != '0);
    assign w_wr    = w_push && !w_full;
    assign w_rd    = w_valid && m_if.m_ready_i;

    always_ff @(posedge aclk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------------------------------------------------------- statistics
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ovf_cnt <= '0;
            r_sup_cnt <= '0;
        end else if (clear_i) begin
            r_ovf_cnt <= '0;
            r_sup_cnt <= '0;
        end else begin
            if (w_push && w_full && (r_ovf_cnt != 16'hFFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
            if ((r_state == S_HOLDOFF) && w_hit_any && (r_sup_cnt != 16'hFFFF)) begin
                r_sup_cnt <= r_sup_cnt + 16'd1;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    // Head word is gated by valid so the stream reads zero while empty/reset.
    assign m_if.m_valid_o = w_valid;
    assign m_if.m_data_o  = w_valid ? r_mem[r_rptr] : '0;
    assign fifo_count_o   = r_count;
    assign overflow_cnt_o = r_ovf_cnt;
    assign suppress_cnt_o = r_sup_cnt;
    assign busy_o         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_l1_trigger_event_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_l1_trigger_event_builder
// Description : Directed self-checking bench for l1_trigger_event_builder
//               with NBEAMS=2, TS_BITS=32, GATHER=4, HOLDOFF=16, DEPTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_trigger_event_builder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  trig_i;
    logic [1:0]  beam_en_i;
    logic        enable_i;
    logic        clear_i;
    logic [4:0]  fifo_count_o;
    logic [15:0] overflow_cnt_o;
    logic [15:0] suppress_cnt_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    l1_trigger_event_builder_if #(.DATA_W(34)) m_if ();

    l1_trigger_event_builder #(
        .NBEAMS         (2),
        .TS_BITS        (32),
        .GATHER_CLOCKS  (4),
        .HOLDOFF_CLOCKS (16),
        .FIFO_DEPTH     (16)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .trig_i         (trig_i),
        .beam_en_i      (beam_en_i),
        .enable_i       (enable_i),
        .clear_i        (clear_i),
        .m_if           (m_if.master),
        .fifo_count_o   (fifo_count_o),
        .overflow_cnt_o (overflow_cnt_o),
        .suppress_cnt_o (suppress_cnt_o),
        .busy_o         (busy_o)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [1:0] mask_of(input int i);
        return i[0] ? 2'b10 : 2'b01;
    endfunction

    // One-cycle clear; afterwards the current cycle has ts=0.
    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; trig_i = 2'b00; beam_en_i = 2'b11; enable_i = 1'b1;
        clear_i = 1'b0; m_if.m_ready_i = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++; if (m_if.m_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%0h expected=0", m_if.m_valid_o); end
        checks++; if (m_if.m_data_o !== 34'h0) begin failures++; $display("FAIL reset_data actual=%0h expected=0", m_if.m_data_o); end
        checks++; if (fifo_count_o !== 5'd0) begin failures++; $display("FAIL reset_count actual=%0d expected=0", fifo_count_o); end
        checks++; if (overflow_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_ovf actual=%0d expected=0", overflow_cnt_o); end
        checks++; if (suppress_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_sup actual=%0d expected=0", suppress_cnt_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%0h expected=0", busy_o); end
        #2 aresetn = 1'b1;
        tick();
    endtask

    task automatic test_coincidence();
        do_clear();                       // ts=0
        repeat (100) tick();              // ts=100
        trig_i = 2'b01; tick();           // ts=101
        trig_i = 2'b00; tick();           // ts=102
        trig_i = 2'b10; tick();           // ts=103
        trig_i = 2'b00;
        checks++; if (m_if.m_valid_o !== 1'b0) begin failures++; $display("FAIL coinc_valid_early actual=%0h expected=0", m_if.m_valid_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL coinc_busy actual=%0h expected=1", busy_o); end
        tick();                           // ts=104
        checks++; if (m_if.m_valid_o !== 1'b1) begin failures++; $display("FAIL coinc_valid actual=%0h expected=1", m_if.m_valid_o); end
        checks++; if (m_if.m_data_o !== {32'd100, 2'b11}) begin failures++; $display("FAIL coinc_data actual=%0h expected=%0h", m_if.m_data_o, {32'd100, 2'b11}); end
        checks++; if (fifo_count_o !== 5'd1) begin failures++; $display("FAIL coinc_count actual=%0d expected=1", fifo_count_o); end
        m_if.m_ready_i = 1'b1; tick(); m_if.m_ready_i = 1'b0;
        checks++; if (fifo_count_o !== 5'd0) begin failures++; $display("FAIL coinc_pop_count actual=%0d expected=0", fifo_count_o); end
        repeat (20) tick();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL coinc_idle actual=%0h expected=0", busy_o); end
    endtask

    task automatic test_holdoff_suppress();
        do_clear();                       // ts=0
        trig_i = 2'b01; tick();           // ts=1
        trig_i = 2'b00;
        repeat (3) tick();                // ts=4, holdoff begins
        checks++; if (m_if.m_data_o !== {32'd0, 2'b01}) begin failures++; $display("FAIL hold_first_data actual=%0h expected=%0h", m_if.m_data_o, {32'd0, 2'b01}); end
        trig_i = 2'b01;
        repeat (16) tick();               // ts=20, back in IDLE with hit present
        checks++; if (suppress_cnt_o !== 16'd16) begin failures++; $display("FAIL hold_suppress actual=%0d expected=16", suppress_cnt_o); end
        checks++; if (fifo_count_o !== 5'd1) begin failures++; $display("FAIL hold_single_event actual=%0d expected=1", fifo_count_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL hold_idle_at_20 actual=%0h expected=0", busy_o); end
        tick();                           // ts=21
        trig_i = 2'b00;
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL hold_restart_busy actual=%0h expected=1", busy_o); end
        repeat (3) tick();                // ts=24
        checks++; if (fifo_count_o !== 5'd2) begin failures++; $display("FAIL hold_second_event actual=%0d expected=2", fifo_count_o); end
        m_if.m_ready_i = 1'b1;
        checks++; if (m_if.m_data_o !== {32'd0, 2'b01}) begin failures++; $display("FAIL hold_pop0 actual=%0h expected=%0h", m_if.m_data_o, {32'd0, 2'b01}); end
        tick();
        checks++; if (m_if.m_data_o !== {32'd20, 2'b01}) begin failures++; $display("FAIL hold_pop1 actual=%0h expected=%0h", m_if.m_data_o, {32'd20, 2'b01}); end
        tick();
        m_if.m_ready_i = 1'b0;
        checks++; if (fifo_count_o !== 5'd0) begin failures++; $display("FAIL hold_drained actual=%0d expected=0", fifo_count_o); end
        repeat (20) tick();
    endtask

    task automatic test_overflow_drain();
        logic [33:0] exp;
        do_clear();                       // ts=0
        for (int i = 0; i < 17; i++) begin
            trig_i = mask_of(i); tick();
            trig_i = 2'b00; repeat (19) tick();
        end                               // ts=340
        checks++; if (fifo_count_o !== 5'd16) begin failures++; $display("FAIL ovf_count actual=%0d expected=16", fifo_count_o); end
        checks++; if (overflow_cnt_o !== 16'd1) begin failures++; $display("FAIL ovf_cnt actual=%0d expected=1", overflow_cnt_o); end
        exp = {32'd0, mask_of(0)};
        checks++; if (m_if.m_data_o !== exp) begin failures++; $display("FAIL ovf_head actual=%0h expected=%0h", m_if.m_data_o, exp); end
        repeat (3) tick();
        checks++; if (m_if.m_data_o !== exp) begin failures++; $display("FAIL ovf_stall_stable actual=%0h expected=%0h", m_if.m_data_o, exp); end
        m_if.m_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = {32'(20 * i), mask_of(i)};
            checks++; if (m_if.m_data_o !== exp) begin failures++; $display("FAIL ovf_drain_%0d actual=%0h expected=%0h", i, m_if.m_data_o, exp); end
            tick();
        end
        m_if.m_ready_i = 1'b0;
        checks++; if (m_if.m_valid_o !== 1'b0) begin failures++; $display("FAIL ovf_empty actual=%0h expected=0", m_if.m_valid_o); end
    endtask

    task automatic test_full_push_pop();
        logic [33:0] exp;
        do_clear();                       // ts=0
        for (int i = 0; i < 16; i++) begin
            trig_i = mask_of(i); tick();
            trig_i = 2'b00; repeat (19) tick();
        end                               // ts=320
        checks++; if (fifo_count_o !== 5'd16) begin failures++; $display("FAIL fpp_full actual=%0d expected=16", fifo_count_o); end
        trig_i = mask_of(16); tick();     // ts=321
        trig_i = 2'b00; tick(); tick();   // ts=323, push cycle
        m_if.m_ready_i = 1'b1; tick();    // ts=324
        m_if.m_ready_i = 1'b0;
        checks++; if (fifo_count_o !== 5'd15) begin failures++; $display("FAIL fpp_count actual=%0d expected=15", fifo_count_o); end
        checks++; if (overflow_cnt_o !== 16'd1) begin failures++; $display("FAIL fpp_ovf actual=%0d expected=1", overflow_cnt_o); end
        exp = {32'd20, mask_of(1)};
        checks++; if (m_if.m_data_o !== exp) begin failures++; $display("FAIL fpp_head actual=%0h expected=%0h", m_if.m_data_o, exp); end
        m_if.m_ready_i = 1'b1; repeat (15) tick(); m_if.m_ready_i = 1'b0;
        checks++; if (fifo_count_o !== 5'd0) begin failures++; $display("FAIL fpp_drained actual=%0d expected=0", fifo_count_o); end
        repeat (5) tick();
    endtask

    task automatic test_enable_and_clear();
        beam_en_i = 2'b01; trig_i = 2'b10;
        repeat (25) tick();
        checks++; if (fifo_count_o !== 5'd0) begin failures++; $display("FAIL beam_en_masked actual=%0d expected=0", fifo_count_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL beam_en_busy actual=%0h expected=0", busy_o); end
        beam_en_i = 2'b11;
        trig_i = 2'b01; tick();           // rel 1
        trig_i = 2'b00; enable_i = 1'b0; tick();   // rel 2
        trig_i = 2'b10; tick();           // rel 3
        trig_i = 2'b00; tick();           // rel 4
        checks++; if (m_if.m_valid_o !== 1'b1) begin failures++; $display("FAIL en_gather_valid actual=%0h expected=1", m_if.m_valid_o); end
        checks++; if (m_if.m_data_o[1:0] !== 2'b11) begin failures++; $display("FAIL en_gather_mask actual=%0h expected=3", m_if.m_data_o[1:0]); end
        trig_i = 2'b01;
        repeat (16) tick();               // rel 20, IDLE, enable_i=0
        tick();
        trig_i = 2'b00;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL en_blocked_busy actual=%0h expected=0", busy_o); end
        checks++; if (suppress_cnt_o !== 16'd16) begin failures++; $display("FAIL en_suppress actual=%0d expected=16", suppress_cnt_o); end
        checks++; if (overflow_cnt_o !== 16'd1) begin failures++; $display("FAIL en_ovf_before_clear actual=%0d expected=1", overflow_cnt_o); end
        do_clear();                       // ts=0
        checks++; if (suppress_cnt_o !== 16'd0) begin failures++; $display("FAIL clr_suppress actual=%0d expected=0", suppress_cnt_o); end
        checks++; if (overflow_cnt_o !== 16'd0) begin failures++; $display("FAIL clr_ovf actual=%0d expected=0", overflow_cnt_o); end
        checks++; if (fifo_count_o !== 5'd1) begin failures++; $display("FAIL clr_no_flush actual=%0d expected=1", fifo_count_o); end
        enable_i = 1'b1; trig_i = 2'b01; m_if.m_ready_i = 1'b1; tick();   // ts=1
        trig_i = 2'b00; m_if.m_ready_i = 1'b0;
        repeat (3) tick();                // ts=4
        checks++; if (m_if.m_data_o !== {32'd0, 2'b01}) begin failures++; $display("FAIL clr_ts actual=%0h expected=%0h", m_if.m_data_o, {32'd0, 2'b01}); end
        m_if.m_ready_i = 1'b1; tick(); m_if.m_ready_i = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_reset_mid_gather();
        for (int i = 0; i < 3; i++) begin
            trig_i = 2'b01; tick();
            trig_i = 2'b00; repeat (19) tick();
        end
        checks++; if (fifo_count_o !== 5'd3) begin failures++; $display("FAIL rst_queued actual=%0d expected=3", fifo_count_o); end
        trig_i = 2'b01; tick();
        trig_i = 2'b00; tick();
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rst_in_gather actual=%0h expected=1", busy_o); end
        #2 aresetn = 1'b0;
        #1;
        checks++; if (m_if.m_valid_o !== 1'b0) begin failures++; $display("FAIL rst_async_valid actual=%0h expected=0", m_if.m_valid_o); end
        checks++; if (m_if.m_data_o !== 34'h0) begin failures++; $display("FAIL rst_async_data actual=%0h expected=0", m_if.m_data_o); end
        checks++; if (fifo_count_o !== 5'd0) begin failures++; $display("FAIL rst_async_count actual=%0d expected=0", fifo_count_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_async_busy actual=%0h expected=0", busy_o); end
        #1 aresetn = 1'b1;
        repeat (10) tick();
        checks++; if (m_if.m_valid_o !== 1'b0) begin failures++; $display("FAIL rst_no_event actual=%0h expected=0", m_if.m_valid_o); end
        checks++; if (fifo_count_o !== 5'd0) begin failures++; $display("FAIL rst_after_count actual=%0d expected=0", fifo_count_o); end
    endtask

    initial begin
        test_reset();
        test_coincidence();
        test_holdoff_suppress();
        test_overflow_drain();
        test_full_push_pop();
        test_enable_and_clear();
        test_reset_mid_gather();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
